// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, op width and FSM state encoding shared by the ALU files
package alu_pkg;
   localparam int OPW = 3;
   localparam logic [OPW-1:0] OP_ADD = 3'd0;
   localparam logic [OPW-1:0] OP_SUB = 3'd1;
   localparam logic [OPW-1:0] OP_AND = 3'd2;
   localparam logic [OPW-1:0] OP_OR  = 3'd3;
   localparam logic [OPW-1:0] OP_XOR = 3'd4;
   localparam logic [OPW-1:0] OP_SHL = 3'd5;
   localparam logic [OPW-1:0] OP_SHR = 3'd6;
   localparam logic [OPW-1:0] OP_MUL = 3'd7;
   typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: W-cycle unsigned shift-add multiplier
// ports: clk_i, rst_i (sync, active-high); start, x, y in; busy, done (last step, comb), product (2W, valid with done)
module alu_mul_seq #(
   parameter int W = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);
   localparam int CW = $clog2(W) + 1;
   logic [W-1:0]   mc;
   logic [2*W-1:0] p;
   logic [CW-1:0]  cnt;
   logic [W:0]     sum;
   // p holds {partial sum, unconsumed multiplier bits}; each step adds mc when the low bit is set and shifts right
   assign sum     = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, mc} : '0);
   assign product = {sum, p[W-1:1]};
   assign done    = busy && cnt == CW'(W - 1);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy <= 1'b0;
         cnt  <= '0;
         p    <= '0;
         mc   <= '0;
      end else if (start && !busy) begin
         busy <= 1'b1;
         cnt  <= '0;
         p    <= {{W{1'b0}}, y};
         mc   <= x;
      end else if (busy) begin
         p    <= product;
         cnt  <= cnt + 1'b1;
         busy <= !done;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with flags; optional multi-cycle MUL when ALU_SEQ_MUL_EN is defined
// ports: clk_i, rst_i (sync, active-high); valid_i, ready_o handshake; x_i, y_i, op_i operands;
//        done_o completion pulse; r_o, rh_o results; fz_o, fc_o, fn_o, fv_o flags (held between completions)
module alu_seq
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [W-1:0]   x_i,
   input  logic [W-1:0]   y_i,
   input  logic [OPW-1:0] op_i,
   output logic           done_o,
   output logic [W-1:0]   r_o,
   output logic [W-1:0]   rh_o,
   output logic           fz_o,
   output logic           fc_o,
   output logic           fn_o,
   output logic           fv_o
);
   logic [W:0]   add, sub;
   logic [W-1:0] r_n, rh_n;
   logic         c_n, v_n, commit;
   assign add = {1'b0, x_i} + {1'b0, y_i};
   assign sub = {1'b0, x_i} - {1'b0, y_i};
`ifdef ALU_SEQ_MUL_EN
   state_t         state;
   logic           ready, accept, mul_busy, mul_done;
   logic [2*W-1:0] prod;
   assign accept  = valid_i && state == ST_IDLE && !mul_busy;
   assign commit  = (accept && op_i != OP_MUL) || mul_done;
   assign ready_o = ready;
   alu_mul_seq #(.W(W)) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (accept && op_i == OP_MUL),
      .x       (x_i),
      .y       (y_i),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (prod)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         ready <= 1'b1;
      end else if (accept && op_i == OP_MUL) begin
         state <= ST_MUL;
         ready <= 1'b0;
      end else if (mul_done) begin
         state <= ST_IDLE;
         ready <= 1'b1;
      end
   end
`else
   assign commit  = valid_i;
   assign ready_o = 1'b1;
`endif
   always_comb begin
      r_n  = '0;
      rh_n = '0;
      c_n  = 1'b0;
      v_n  = 1'b0;
      case (op_i)
         OP_ADD: begin
            {c_n, r_n} = add;
            v_n = (x_i[W-1] == y_i[W-1]) && (add[W-1] != x_i[W-1]);
         end
         OP_SUB: begin
            {c_n, r_n} = sub;
            v_n = (x_i[W-1] != y_i[W-1]) && (sub[W-1] != x_i[W-1]);
         end
         OP_AND: r_n = x_i & y_i;
         OP_OR:  r_n = x_i | y_i;
         OP_XOR: r_n = x_i ^ y_i;
         OP_SHL: {c_n, r_n} = {x_i, 1'b0};
         OP_SHR: {r_n, c_n} = {1'b0, x_i};
         default: ;
      endcase
`ifdef ALU_SEQ_MUL_EN
      // a finishing multiply owns the result registers; no other op can be in flight then
      if (mul_done) begin
         {rh_n, r_n} = prod;
         c_n = |prod[2*W-1:W];
         v_n = 1'b0;
      end
`endif
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_o <= 1'b0;
         r_o    <= '0;
         rh_o   <= '0;
         fz_o   <= 1'b1;
         fc_o   <= 1'b0;
         fn_o   <= 1'b0;
         fv_o   <= 1'b0;
      end else begin
         done_o <= commit;
         if (commit) begin
            r_o  <= r_n;
            rh_o <= rh_n;
            fz_o <= r_n == '0;
            fc_o <= c_n;
            fn_o <= r_n[W-1];
            fv_o <= v_n;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at W=8 and W=16
module tb_alu_seq;
   import alu_pkg::*;
   logic clk = 1'b0, rst = 1'b0;
   logic valid = 1'b0, valid16 = 1'b0;
   logic [2:0] op = 3'd0, op16 = 3'd0;
   logic [7:0] x = '0, y = '0;
   logic [15:0] x16 = '0, y16 = '0;
   logic ready, done, fz, fc, fn, fv;
   logic [7:0] r, rh;
   logic ready16, done16, fz16, fc16, fn16, fv16;
   logic [15:0] r16, rh16;
   logic [20:0] o8, e8;
   logic [36:0] o16, e16;
   int n_cmp = 0, n_err = 0;
   assign o8  = {done, r, rh, fz, fc, fn, fv};
   assign o16 = {done16, r16, rh16, fz16, fc16, fn16, fv16};
   always #5 clk = ~clk;

   alu_seq #(.W(8)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .x_i(x), .y_i(y), .op_i(op),
      .done_o(done), .r_o(r), .rh_o(rh), .fz_o(fz), .fc_o(fc), .fn_o(fn), .fv_o(fv));
   alu_seq #(.W(16)) dut16 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid16), .ready_o(ready16), .x_i(x16), .y_i(y16), .op_i(op16),
      .done_o(done16), .r_o(r16), .rh_o(rh16), .fz_o(fz16), .fc_o(fc16), .fn_o(fn16), .fv_o(fv16));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      valid = 1'b1;
      op = o;
      x = a;
      y = b;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      e8 = {1'b0, 8'h00, 8'h00, 4'b1000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL reset8 got=%h exp=%h", o8, e8); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
      e16 = {1'b0, 16'h0, 16'h0, 4'b1000};
      n_cmp++; if (o16 !== e16) begin n_err++; $display("FAIL reset16 got=%h exp=%h", o16, e16); end
   endtask

   task automatic test_add();
      drive(OP_ADD, 8'd1, 8'd1);
      step();
      valid = 1'b0;
      e8 = {1'b1, 8'd2, 8'd0, 4'b0000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL add_1_1 got=%h exp=%h", o8, e8); end
      x = 8'hFF;
      step();
      e8 = {1'b0, 8'd2, 8'd0, 4'b0000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL add_hold got=%h exp=%h", o8, e8); end
      drive(OP_ADD, 8'd255, 8'd1);
      step();
      e8 = {1'b1, 8'd0, 8'd0, 4'b1100};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL add_255_1 got=%h exp=%h", o8, e8); end
      drive(OP_ADD, 8'd127, 8'd1);
      step();
      valid = 1'b0;
      e8 = {1'b1, 8'd128, 8'd0, 4'b0011};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL add_127_1 got=%h exp=%h", o8, e8); end
   endtask

   task automatic test_back_to_back();
      drive(OP_SUB, 8'd7, 8'd3);
      step();
      e8 = {1'b1, 8'd4, 8'd0, 4'b0000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL sub_7_3 got=%h exp=%h", o8, e8); end
      drive(OP_SUB, 8'd2, 8'd2);
      step();
      e8 = {1'b1, 8'd0, 8'd0, 4'b1000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL sub_2_2 got=%h exp=%h", o8, e8); end
      drive(OP_SUB, 8'd3, 8'd4);
      step();
      valid = 1'b0;
      e8 = {1'b1, 8'd255, 8'd0, 4'b0110};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL sub_3_4 got=%h exp=%h", o8, e8); end
      step();
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_idle_done got=%b exp=0", done); end
   endtask

   task automatic test_logic();
      drive(OP_AND, 8'hF0, 8'h3C);
      step();
      e8 = {1'b1, 8'h30, 8'd0, 4'b0000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL and got=%h exp=%h", o8, e8); end
      drive(OP_OR, 8'hF0, 8'h0C);
      step();
      e8 = {1'b1, 8'hFC, 8'd0, 4'b0010};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL or got=%h exp=%h", o8, e8); end
      drive(OP_XOR, 8'hAA, 8'hAA);
      step();
      valid = 1'b0;
      e8 = {1'b1, 8'h00, 8'd0, 4'b1000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL xor got=%h exp=%h", o8, e8); end
   endtask

   task automatic test_shift();
      drive(OP_SHL, 8'h81, 8'h55);
      step();
      e8 = {1'b1, 8'h02, 8'd0, 4'b0100};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL shl_81 got=%h exp=%h", o8, e8); end
      drive(OP_SHR, 8'h81, 8'hAA);
      step();
      valid = 1'b0;
      e8 = {1'b1, 8'h40, 8'd0, 4'b0100};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL shr_81 got=%h exp=%h", o8, e8); end
   endtask

   task automatic test_mul();
      int bad;
      drive(OP_MUL, 8'd15, 8'd17);
      step();
      valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (done !== 1'b0 || ready !== 1'b0) bad++;
         step();
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mul_busy_cycles got=%0d bad exp=0", bad); end
      e8 = {1'b1, 8'd255, 8'd0, 4'b0010};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL mul_15_17 got=%h exp=%h", o8, e8); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mul_ready_back got=%b exp=1", ready); end
      drive(OP_MUL, 8'd255, 8'd255);
      step();
      drive(OP_ADD, 8'd1, 8'd1);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (done !== 1'b0 || ready !== 1'b0) bad++;
         step();
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mul_valid_ignored got=%0d bad exp=0", bad); end
      e8 = {1'b1, 8'h01, 8'hFE, 4'b0100};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL mul_255_255 got=%h exp=%h", o8, e8); end
      step();
      valid = 1'b0;
      e8 = {1'b1, 8'd2, 8'd0, 4'b0000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL add_after_mul got=%h exp=%h", o8, e8); end
   endtask

   task automatic test_mul_disabled();
      drive(OP_MUL, 8'd5, 8'd5);
      step();
      valid = 1'b0;
      e8 = {1'b1, 8'd0, 8'd0, 4'b1000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL mul_off got=%h exp=%h", o8, e8); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mul_off_ready got=%b exp=1", ready); end
   endtask

   task automatic test_reset_mid_mul();
      int pulses;
      drive(OP_ADD, 8'd3, 8'd4);
      step();
      drive(OP_MUL, 8'd15, 8'd17);
      step();
      valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      e8 = {1'b0, 8'd0, 8'd0, 4'b1000};
      n_cmp++; if (o8 !== e8) begin n_err++; $display("FAIL rst_mid_mul got=%h exp=%h", o8, e8); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_mul_ready got=%b exp=1", ready); end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done !== 1'b0) pulses++;
         step();
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_mid_mul_no_done got=%0d exp=0", pulses); end
   endtask

   task automatic test_w16();
      valid16 = 1'b1;
      op16 = OP_ADD;
      x16 = 16'hFFFF;
      y16 = 16'h0001;
      step();
      valid16 = 1'b0;
      e16 = {1'b1, 16'h0, 16'h0, 4'b1100};
      n_cmp++; if (o16 !== e16) begin n_err++; $display("FAIL w16_add got=%h exp=%h", o16, e16); end
   endtask

   initial begin
      step();
      test_reset();
      test_add();
      test_back_to_back();
      test_logic();
`ifdef ALU_SEQ_MUL_EN
      test_mul();
`else
      test_mul_disabled();
`endif
      test_reset_mid_mul();
      test_shift();
      test_w16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
